systolic_gemm: RTL and testbench

Output-stationary M×K systolic matrix-multiply engine computing Y = X·W over a runtime reduction length N, with internal input skewing, valid/ready streaming on both sides and a start/done control FSM. Generalises the fixed-schedule systolic array: operand staggering and drain are handled internally, the array freezes on input bubbles, and results are read out row by row under backpressure. Sits between the operand-fetch DMA and the result write-back buffer.

---
 rtl/systolic_gemm_if.sv | 35 +++
 rtl/systolic_gemm.sv | 243 ++++++++++++++++++++++++
 tb/tb_systolic_gemm.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_gemm_if.sv
// systolic_gemm_if: operand stream, result stream and job control bundle for
// the systolic GEMM engine. The master side is the fetch/write-back
// environment; the slave side is the engine.
interface systolic_gemm_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int LEN_W      = 8
);
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  logic                    start;
  logic [LEN_W-1:0]        n_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH*M-1:0] x_in;
  logic [DATA_WIDTH*K-1:0] w_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH*K-1:0]  y_out;
  logic [RW-1:0]           out_row;
  logic                    busy;
  logic                    done;

  modport master (
    output start, n_len, in_valid, x_in, w_in, out_ready,
    input  in_ready, out_valid, y_out, out_row, busy, done
  );

  modport slave (
    input  start, n_len, in_valid, x_in, w_in, out_ready,
    output in_ready, out_valid, y_out, out_row, busy, done
  );
endinterface

// File: rtl/systolic_gemm.sv
// systolic_gemm: output-stationary MxK systolic matrix multiply, Y = X*W,
// runtime reduction length, internal operand skew, stall-on-bubble array,
// row-by-row result readout with backpressure.
// Build option: define SYSTOLIC_GEMM_SAT_EN for saturating (sticky)
// accumulation; otherwise accumulators wrap modulo 2^ACC_WIDTH.

// Tapped delay line: tap t presents d delayed by D0+t enabled cycles. One
// shared shift register per row/column, so each tap beyond the first is the
// PE-to-PE hop register of the systolic flow.
module systolic_gemm_tap #(
  parameter int W  = 8,
  parameter int D0 = 0,
  parameter int NT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [W-1:0]         d,
  output logic [NT-1:0][W-1:0] q
);
  localparam int L  = D0 + NT - 1;
  localparam int LS = (L > 0) ? L : 1;

  logic [LS-1:0][W-1:0] sr;

  if (L > 0) begin : g_sr
    // shift only on enabled cycles so a stalled array holds its wavefront
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= '0;
      else if (clr) sr <= '0;
      else if (en) begin
        sr[0] <= d;
        for (int k = 1; k < L; k++) sr[k] <= sr[k-1];
      end
  end else begin : g_nosr
    assign sr = '0;
  end

  for (genvar t = 0; t < NT; t++) begin : g_tap
    if (D0 + t == 0) begin : g_thru
      assign q[t] = d;
    end else begin : g_dly
      assign q[t] = sr[D0+t-1];
    end
  end
endmodule

// Processing element: signed multiply-accumulate. acc_nxt is the value the
// accumulator takes at the coming edge, so readout can capture a row on the
// same edge as the final update.
module systolic_gemm_pe #(
  parameter int DW = 8,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] w,
  output logic [AW-1:0] acc_nxt
);
  logic [AW-1:0]        acc;
  logic signed [2*DW-1:0] prod;

  assign prod = $signed(x) * $signed(w);

`ifdef SYSTOLIC_GEMM_SAT_EN
  logic [AW:0] sum;
  logic        sat_q;
  logic        ovf;

  assign sum = {acc[AW-1], acc} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
  assign ovf = en && !sat_q && (sum[AW] != sum[AW-1]);

  // clamp on overflow; once clamped the element stays put for the job
  always_comb begin
    acc_nxt = acc;
    if (ovf) acc_nxt = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    else if (en && !sat_q) acc_nxt = sum[AW-1:0];
  end

  // accumulator and sticky clamp flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc <= acc_nxt;
      if (ovf) sat_q <= 1'b1;
    end
`else
  logic [AW-1:0] sum;

  assign sum = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};

  // wrap-around accumulation
  always_comb begin
    acc_nxt = acc;
    if (en) acc_nxt = sum;
  end

  // accumulator
  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else if (clr) acc <= '0;
    else acc <= acc_nxt;
`endif
endmodule

module systolic_gemm #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int LEN_W      = 8
) (
  input  logic          clk,
  input  logic          rst,
  systolic_gemm_if.slave io
);
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = ACC_WIDTH;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int DRN = M + K - 2;
  localparam int DCW = $clog2(M + K);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  logic [2:0]                   state;
  logic [LEN_W-1:0]             n_q, beat_q;
  logic [DCW-1:0]               drn_q;
  logic [RW-1:0]                row_q;
  logic [K-1:0][AW-1:0]         y_q;
  logic                         en, clr;
  logic [M-1:0][DW-1:0]         xf;
  logic [K-1:0][DW-1:0]         wf;
  logic [M-1:0][K-1:0][DW-1:0]  xop;
  logic [K-1:0][M-1:0][DW-1:0]  wop;
  logic [M-1:0][K-1:0][AW-1:0]  acc_nxt;

  // array advances on accepted beats and on every drain cycle
  assign en  = (state == S_STREAM && io.in_valid) || state == S_DRAIN;
  assign clr = state == S_IDLE && io.start;
  // drain pushes zeros behind the last real beat
  assign xf  = (state == S_STREAM) ? io.x_in : '0;
  assign wf  = (state == S_STREAM) ? io.w_in : '0;

  assign io.in_ready  = state == S_STREAM;
  assign io.out_valid = state == S_OUT;
  assign io.busy      = state != S_IDLE;
  assign io.done      = state == S_FIN;
  assign io.y_out     = y_q;
  assign io.out_row   = row_q;

  // x row i: skew i, then one hop per column; w column j: skew j, one hop per row
  for (genvar i = 0; i < M; i++) begin : g_xrow
    systolic_gemm_tap #(.W(DW), .D0(i), .NT(K)) u_xtap (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(xf[i]), .q(xop[i])
    );
  end
  for (genvar j = 0; j < K; j++) begin : g_wcol
    systolic_gemm_tap #(.W(DW), .D0(j), .NT(M)) u_wtap (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .d(wf[j]), .q(wop[j])
    );
  end

  for (genvar i = 0; i < M; i++) begin : g_pr
    for (genvar j = 0; j < K; j++) begin : g_pc
      systolic_gemm_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .x(xop[i][j]), .w(wop[j][i]), .acc_nxt(acc_nxt[i][j])
      );
    end
  end

  // job control: accept, stream N beats, drain skew, read rows out, pulse done
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= S_IDLE;
      n_q    <= '0;
      beat_q <= '0;
      drn_q  <= '0;
      row_q  <= '0;
      y_q    <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (io.start) begin
            n_q    <= io.n_len;
            beat_q <= '0;
            if (io.n_len == '0) begin
              state <= S_OUT;
              row_q <= '0;
              y_q   <= '0;
            end else begin
              state <= S_STREAM;
            end
          end
        S_STREAM:
          if (io.in_valid) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == n_q - 1'b1) begin
              if (DRN == 0) begin
                state <= S_OUT;
                row_q <= '0;
                y_q   <= acc_nxt[0];
              end else begin
                state <= S_DRAIN;
                drn_q <= '0;
              end
            end
          end
        S_DRAIN: begin
          drn_q <= drn_q + 1'b1;
          if (drn_q == DCW'(DRN - 1)) begin
            state <= S_OUT;
            row_q <= '0;
            y_q   <= acc_nxt[0];
          end
        end
        S_OUT:
          if (io.out_ready) begin
            if (row_q == RW'(M - 1)) begin
              state <= S_FIN;
            end else begin
              row_q <= row_q + 1'b1;
              y_q   <= acc_nxt[row_q + 1'b1];
            end
          end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_systolic_gemm.sv
// tb_systolic_gemm: directed bench for systolic_gemm (4x4, 16-bit results).
module tb_systolic_gemm;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int M  = 4;
  localparam int K  = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_gemm_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .M(M), .K(K), .LEN_W(LW)) g ();

  systolic_gemm #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .M(M), .K(K), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .io(g)
  );

  int total = 0, bad = 0, cyc = 0, done_cnt = 0;
  int xb[8][M];
  int wb[8][K];
  int ey[M][K];
  int ts, tov, tdn, dc;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge g.done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input int r);
    logic [AW-1:0] e;
    chk($sformatf("%s_row", tag), 64'(g.out_row), 64'(r));
    for (int j = 0; j < K; j++) begin
      e = AW'(ey[r][j]);
      chk($sformatf("%s_y%0d_%0d", tag, r, j), 64'(g.y_out[j*AW +: AW]), 64'(e));
    end
  endtask

  task automatic drive(input int t, input logic v);
    for (int i = 0; i < M; i++) g.x_in[i*DW +: DW] = v ? DW'(xb[t][i]) : 8'h55;
    for (int j = 0; j < K; j++) g.w_in[j*DW +: DW] = v ? DW'(wb[t][j]) : 8'h33;
    g.in_valid = v;
  endtask

  task automatic start_job(input int n, output int t_st);
    g.start = 1'b1;
    g.n_len = LW'(n);
    @(negedge clk);
    g.start = 1'b0;
    t_st = cyc;
  endtask

  // pat bit c = in_valid in stream cycle c; cycles past plen are valid
  task automatic stream(input int n, input logic [15:0] pat, input int plen);
    int fired = 0;
    int c = 0;
    logic v;
    while (fired < n && c < 64) begin
      chk("in_ready_on", 64'(g.in_ready), 64'd1);
      v = (c < plen) ? pat[c] : 1'b1;
      drive(fired, v);
      @(negedge clk);
      if (v) fired++;
      c++;
    end
    chk("stream_beats", 64'(fired), 64'(n));
    drive(0, 1'b1);
    chk("in_ready_drop", 64'(g.in_ready), 64'd0);
    @(negedge clk);
    g.in_valid = 1'b0;
  endtask

  task automatic read_rows(input logic stall, output int t_ov, output int t_dn);
    int k = 0;
    g.out_ready = !stall;
    while (!g.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    t_ov = cyc;
    chk("out_valid_wait", 64'(k < 100), 64'd1);
    for (int r = 0; r < M; r++) begin
      if (stall) begin
        for (int s = 0; s < 2; s++) begin
          g.out_ready = 1'b0;
          chk("stall_valid", 64'(g.out_valid), 64'd1);
          chk_row("stall", r);
          @(negedge clk);
        end
      end
      g.out_ready = 1'b1;
      chk("rd_valid", 64'(g.out_valid), 64'd1);
      chk_row("rd", r);
      @(negedge clk);
    end
    g.out_ready = 1'b0;
    t_dn = cyc;
    chk("done_hi", 64'(g.done), 64'd1);
    chk("busy_fin", 64'(g.busy), 64'd1);
    chk("valid_fin", 64'(g.out_valid), 64'd0);
    @(negedge clk);
    chk("done_lo", 64'(g.done), 64'd0);
    chk("busy_idle", 64'(g.busy), 64'd0);
  endtask

  task automatic load_ident();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < M; i++) xb[t][i] = (i == t) ? 1 : 0;
      for (int j = 0; j < K; j++) wb[t][j] = 4 * t + j + 1;
    end
    for (int r = 0; r < M; r++)
      for (int j = 0; j < K; j++) ey[r][j] = 4 * r + j + 1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(g.in_ready), 64'd0);
    chk({tag, "_out_valid"}, 64'(g.out_valid), 64'd0);
    chk({tag, "_y_out"}, 64'(g.y_out), 64'd0);
    chk({tag, "_out_row"}, 64'(g.out_row), 64'd0);
    chk({tag, "_busy"}, 64'(g.busy), 64'd0);
    chk({tag, "_done"}, 64'(g.done), 64'd0);
  endtask

  initial begin
    g.start = 1'b0; g.n_len = '0; g.in_valid = 1'b0; g.out_ready = 1'b0;
    g.x_in = '0; g.w_in = '0;
    @(negedge clk);
    chk_reset("rst0");
    rst = 1'b0;
    @(negedge clk);

    // identity X: rows come out as W rows, unstalled latency
    load_ident();
    start_job(4, ts);
    stream(4, 16'h0000, 0);
    read_rows(1'b0, tov, tdn);
    chk("lat_out_valid", 64'(tov - ts), 64'd10);
    chk("lat_done", 64'(tdn - tov), 64'd4);
    chk("done_cnt1", 64'(done_cnt), 64'd1);

    // N=3 with input bubbles, negative operands, stalled readout
    xb[0] = '{1, -1, 2, 0};  xb[1] = '{2, 0, -3, 1};  xb[2] = '{3, 2, 1, -2};
    wb[0] = '{1, 0, -1, 2};  wb[1] = '{3, 1, 0, -2};  wb[2] = '{-1, 2, 1, 1};
    ey[0] = '{4, 8, 2, 1};   ey[1] = '{-3, 4, 3, 0};
    ey[2] = '{-8, -1, -1, 11}; ey[3] = '{5, -3, -2, -4};
    start_job(3, ts);
    g.start = 1'b1;           // must be ignored while busy
    g.n_len = 8'd7;
    stream(3, 16'b10_1001, 6);
    g.start = 1'b0;
    read_rows(1'b1, tov, tdn);
    chk("done_cnt2", 64'(done_cnt), 64'd2);

    // zero-length job: no operand phase, all-zero rows
    for (int r = 0; r < M; r++) for (int j = 0; j < K; j++) ey[r][j] = 0;
    start_job(0, ts);
    chk("n0_in_ready", 64'(g.in_ready), 64'd0);
    chk("n0_out_valid", 64'(g.out_valid), 64'd1);
    read_rows(1'b0, tov, tdn);
    chk("done_cnt3", 64'(done_cnt), 64'd3);

    // 4 x 127*127 overflows 16 bits
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 4; i++) begin
        xb[t][i] = 127;
        wb[t][i] = 127;
      end
    for (int r = 0; r < M; r++)
      for (int j = 0; j < K; j++)
`ifdef SYSTOLIC_GEMM_SAT_EN
        ey[r][j] = 32767;
`else
        ey[r][j] = -1020;
`endif
    start_job(4, ts);
    stream(4, 16'h0000, 0);
    read_rows(1'b0, tov, tdn);

    // reset during drain aborts without done, then a clean job
    load_ident();
    dc = done_cnt;
    start_job(3, ts);
    stream(3, 16'h0000, 0);
    chk("drain_busy", 64'(g.busy), 64'd1);
    chk("drain_valid", 64'(g.out_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_drain");
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(dc));
    start_job(4, ts);
    stream(4, 16'h0000, 0);
    read_rows(1'b0, tov, tdn);
    chk("done_cnt_after", 64'(done_cnt), 64'(dc + 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
